// File: rtl/wait_arbiter_if.sv
// wait_arbiter_if
//   Bundles the requester and timer signals of wait_arbiter.
//   Parameters: N_REQ (requesters), TICK_W (delay width).
//   Signals:
//     req       requester -> arbiter   level request per requester
//     req_tick  requester -> arbiter   delay per requester, slice i = [i*TICK_W +: TICK_W]
//     gnt       arbiter -> requester   one-hot timer owner
//     done      arbiter -> requester   one-cycle completion pulse
//     tmr_start arbiter -> Wait        start pulse
//     tmr_tick  arbiter -> Wait        delay value
//     tmr_out   Wait -> arbiter        expiry
//     busy      arbiter status         high whenever not idle
//     err       arbiter status         timeout pulse
//   Modports: slave = arbiter side, master = environment side.
interface wait_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TICK_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*TICK_W-1:0] req_tick;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic                    tmr_start;
  logic [TICK_W-1:0]       tmr_tick;
  logic                    tmr_out;
  logic                    busy;
  logic                    err;

  modport slave (
    input  req, req_tick, tmr_out,
    output gnt, done, tmr_start, tmr_tick, busy, err
  );

  modport master (
    output req, req_tick, tmr_out,
    input  gnt, done, tmr_start, tmr_tick, busy, err
  );
endinterface

// File: rtl/wait_arbiter.sv
// wait_arbiter
//   Shares one Wait delay timer among N_REQ requesters, granting them
//   round-robin. A grant latches the requester index and its delay, pulses
//   the timer start, waits for the timer expiry, then pulses done back to
//   the owner. A zero delay skips the timer entirely.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    wait_arbiter_if.slave (req, req_tick, tmr_out in;
//            gnt, done, tmr_start, tmr_tick, busy, err out)
//   Optional feature: define WAIT_ARB_TIMEOUT_EN to build an 8-bit WAIT
//   watchdog that forces DONE with err after 255 WAIT cycles without expiry.
//   Without it, err is tied low and WAIT lasts until tmr_out.
module wait_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TICK_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wait_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [TICK_W-1:0]  tick;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   done_reg;
  logic               start_reg;
  logic               busy_reg;

  logic [IDX_W-1:0]   pick;
  logic [N_REQ-1:0]   pick_onehot;
  logic [TICK_W-1:0]  pick_tick;
  logic [IDX_W-1:0]   rr_next;
  logic [TICK_W-1:0]  req_tick_arr [N_REQ];

`ifdef WAIT_ARB_TIMEOUT_EN
  logic [7:0]         cnt;
  logic               err_reg;
`endif

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_tick_arr[gi] = bus.req_tick[gi*TICK_W +: TICK_W];
    end
  endgenerate

  // First set request at or after rr_ptr, searching upward with wrap.
  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  assign pick_tick = req_tick_arr[pick];

  // The just-served requester drops to lowest priority.
  assign rr_next = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

  // Outputs are registered alongside the state so each one is high exactly
  // for the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rr_ptr    <= '0;
      tick      <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef WAIT_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      done_reg  <= '0;
      start_reg <= 1'b0;
`ifdef WAIT_ARB_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req) begin
            idx      <= pick;
            tick     <= pick_tick;
            gnt_reg  <= pick_onehot;
            busy_reg <= 1'b1;
            if (pick_tick != '0) begin
              state     <= START;
              start_reg <= 1'b1;
            end else begin
              // Zero delay: skip the timer and complete straight away.
              state    <= DONE;
              done_reg <= pick_onehot;
            end
          end
        end
        START: begin
          state <= WAIT;
`ifdef WAIT_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (bus.tmr_out) begin
            state    <= DONE;
            done_reg <= gnt_reg;
          end
`ifdef WAIT_ARB_TIMEOUT_EN
          // The increment that would reach 255 is the timeout instead.
          else if (cnt == 8'd254) begin
            state    <= DONE;
            done_reg <= gnt_reg;
            err_reg  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state    <= IDLE;
          rr_ptr   <= rr_next;
          gnt_reg  <= '0;
          busy_reg <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.done      = done_reg;
  assign bus.tmr_start = start_reg;
  assign bus.tmr_tick  = tick;
  assign bus.busy      = busy_reg;
`ifdef WAIT_ARB_TIMEOUT_EN
  assign bus.err       = err_reg;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_wait_arbiter.sv
// tb_wait_arbiter
//   Drives wait_arbiter through directed scenarios with a behavioural Wait
//   timer model, compares every output each cycle against a transaction-level
//   model of the arbiter, and pins the model with hand-computed expectations.
module tb_wait_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
`ifdef WAIT_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wait_arbiter_if #(.N_REQ(N), .TICK_W(TW)) bus ();
  wait_arbiter #(.N_REQ(N), .TICK_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Wait timer model: loads on start, expires tmr_tick cycles later.
  bit timer_en = 1'b1;
  bit stray    = 1'b0;
  int t_cnt;
  bit t_run;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_run = 1'b0;
      t_cnt = 0;
      bus.tmr_out = 1'b0;
    end else begin
      bus.tmr_out = 1'b0;
      if (stray) begin
        bus.tmr_out = 1'b1;
      end else if (bus.tmr_start && timer_en) begin
        t_cnt = int'(bus.tmr_tick);
        t_run = 1'b1;
      end else if (t_run) begin
        t_cnt--;
        if (t_cnt == 0) begin
          bus.tmr_out = 1'b1;
          t_run = 1'b0;
        end
      end
    end
  end

  // Arbiter model: one grant record; phase 0 = start pulse, 1 = waiting
  // for expiry, 2 = completion cycle.
  bit m_active;
  int m_owner, m_tick, m_phase, m_age, m_last;
  bit m_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_owner = 0; m_tick = 0; m_phase = 0;
      m_age = 0; m_last = N - 1; m_err = 1'b0;
    end else if (!m_active) begin
      if (bus.req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (bus.req[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_tick   = int'((bus.req_tick >> (m_owner * TW)) & ((1 << TW) - 1));
        m_active = 1'b1;
        m_err    = 1'b0;
        m_phase  = (m_tick == 0) ? 2 : 0;
      end
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_age = 0; end
        1: begin
          if (bus.tmr_out) m_phase = 2;
          else if (TIMEOUT && m_age == 254) begin m_phase = 2; m_err = 1'b1; end
          else m_age++;
        end
        default: begin m_active = 1'b0; m_last = m_owner; end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] eg;
    eg = m_active ? (32'd1 << m_owner) : 32'd0;
    chk("gnt", 32'(bus.gnt), eg);
    chk("done", 32'(bus.done), (m_active && m_phase == 2) ? eg : 32'd0);
    chk("tmr_start", 32'(bus.tmr_start), 32'(m_active && m_phase == 0));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("err", 32'(bus.err), 32'(m_active && m_phase == 2 && m_err));
    if (m_active) chk("tmr_tick", 32'(bus.tmr_tick), 32'(m_tick));
  end

  // Event log for literal checks.
  int start_q[$];
  int start_tick_q[$];
  int done_cyc_q[$];
  int done_own_q[$];
  int done_err_q[$];
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (bus.tmr_start) begin
      start_q.push_back(cyc);
      start_tick_q.push_back(int'(bus.tmr_tick));
    end
    if (bus.done != '0) begin
      int o;
      o = 0;
      for (int i = 0; i < N; i++) if (bus.done[i]) o = i;
      done_cyc_q.push_back(cyc);
      done_own_q.push_back(o);
      done_err_q.push_back(int'(bus.err));
      $display("done: owner %0d cycle %0d err %0d", o, cyc, bus.err);
    end
    if (bus.busy) busy_cnt++;
  end

  task automatic wait_done(input int budget, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.done != '0) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int s0, d0, b0, rc;
    int exp_order [5];
    int exp_tick  [5];
    bit seen;
    exp_order = '{0, 1, 2, 3, 0};
    exp_tick  = '{1, 2, 3, 4, 1};
    bus.req = '0;
    bus.req_tick = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tmr_tick", 32'(bus.tmr_tick), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single request, tick 3
    @(negedge clk);
    bus.req_tick = 16'h0003; bus.req = 4'b0001;
    rc = cyc; s0 = start_q.size(); d0 = done_cyc_q.size();
    wait_done(50, "t1");
    bus.req = '0;
    @(posedge clk); #1;
    chk("t1_start_count", 32'(start_q.size() - s0), 32'd1);
    chk("t1_start_lat", 32'(start_q[s0] - rc), 32'd1);
    chk("t1_tmr_tick", 32'(start_tick_q[s0]), 32'd3);
    chk("t1_owner", 32'(done_own_q[d0]), 32'd0);
    chk("t1_done_lat", 32'(done_cyc_q[d0] - start_q[s0]), 32'd4);
    repeat (2) @(negedge clk);
    chk("t1_busy_low", 32'(bus.busy), 32'd0);

    // All four held, ticks 1/2/3/4
    do_reset();
    @(negedge clk);
    bus.req_tick = 16'h4321; bus.req = 4'b1111;
    s0 = start_q.size(); d0 = done_cyc_q.size();
    for (int i = 0; i < 5; i++) wait_done(50, "t2");
    bus.req = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 32'(done_own_q[d0+i]), 32'(exp_order[i]));
      chk("t2_tick", 32'(start_tick_q[s0+i]), 32'(exp_tick[i]));
      chk("t2_done_lat", 32'(done_cyc_q[d0+i] - start_q[s0+i]), 32'(exp_tick[i] + 1));
    end
    chk("t2_b2b_gap", 32'(start_q[s0+1] - done_cyc_q[d0]), 32'd2);

    // Zero tick on requester 2
    repeat (2) @(negedge clk);
    bus.req_tick = 16'h7077; bus.req = 4'b0100;
    rc = cyc; s0 = start_q.size(); d0 = done_cyc_q.size(); b0 = busy_cnt;
    wait_done(20, "t3");
    bus.req = '0;
    @(posedge clk); #1;
    chk("t3_no_start", 32'(start_q.size() - s0), 32'd0);
    chk("t3_owner", 32'(done_own_q[d0]), 32'd2);
    chk("t3_done_lat", 32'(done_cyc_q[d0] - rc), 32'd1);
    chk("t3_busy_cycles", 32'(busy_cnt - b0), 32'd1);

    // Reset during WAIT for requester 1
    repeat (2) @(negedge clk);
    bus.req_tick = 16'h0040; bus.req = 4'b0010;
    d0 = done_cyc_q.size();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.tmr_start) seen = 1'b1;
    end
    chk("t4_start_seen", 32'(seen), 32'd1);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("t4_rst_done", 32'(bus.done), 32'd0);
    chk("t4_rst_start", 32'(bus.tmr_start), 32'd0);
    chk("t4_rst_tick", 32'(bus.tmr_tick), 32'd0);
    chk("t4_rst_busy", 32'(bus.busy), 32'd0);
    chk("t4_rst_err", 32'(bus.err), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t4_no_done", 32'(done_cyc_q.size() - d0), 32'd0);
    wait_done(50, "t4");
    bus.req = '0;
    @(posedge clk); #1;
    chk("t4_regrant_owner", 32'(done_own_q[d0]), 32'd1);
    chk("t4_regrant_lat", 32'(done_cyc_q[d0] - start_q[start_q.size()-1]), 32'd5);

    // Stray tmr_out in IDLE, then tick 5
    repeat (2) @(posedge clk);
    #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 32'(bus.busy), 32'd0);
    bus.req_tick = 16'h0005; bus.req = 4'b0001;
    s0 = start_q.size(); d0 = done_cyc_q.size();
    wait_done(50, "t5");
    bus.req = '0;
    @(posedge clk); #1;
    chk("t5_owner", 32'(done_own_q[d0]), 32'd0);
    chk("t5_done_lat", 32'(done_cyc_q[d0] - start_q[s0]), 32'd6);

    // Timer never expires
    repeat (2) @(negedge clk);
    timer_en = 1'b0;
    bus.req_tick = 16'h2000; bus.req = 4'b1000;
    s0 = start_q.size(); d0 = done_cyc_q.size();
`ifdef WAIT_ARB_TIMEOUT_EN
    wait_done(400, "t6");
    bus.req = '0;
    @(posedge clk); #1;
    chk("t6_owner", 32'(done_own_q[d0]), 32'd3);
    chk("t6_err", 32'(done_err_q[d0]), 32'd1);
    chk("t6_timeout_lat", 32'(done_cyc_q[d0] - start_q[s0]), 32'd256);
`else
    repeat (300) @(negedge clk);
    chk("t6_busy_held", 32'(bus.busy), 32'd1);
    chk("t6_no_done", 32'(done_cyc_q.size() - d0), 32'd0);
    bus.req = '0;
    do_reset();
`endif
    timer_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wait_arbiter.md
# wait_arbiter

- Shares one `Wait` delay timer among `N_REQ` LED-pattern requesters.
- Each requester asks for a delay of `req_tick` timer ticks.
- The arbiter grants requesters round-robin, loads and starts the timer, waits for expiry, and signals completion back to the granted requester.
- It sits between the LED pattern engines and the single `Wait` instance, which drives the timer's `start`/`tick` inputs and consumes its `out`.

## Interface

**Parameters**

- `N_REQ`, default 4: number of requesters, 2..8.
- `TICK_W`, default 4: width of a delay value; matches the `Wait` `tick` port.

**Ports**

- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  level request per requester; the requester holds it until its `done`.
- `req_tick`  in  N_REQ*TICK_W  delay per requester; slice i is `[i*TICK_W +: TICK_W]`, sampled at grant.
- `gnt`  out  N_REQ  one-hot owner of the timer; all zero when idle.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `tmr_start`  out  1  one-cycle start pulse to `Wait.start`.
- `tmr_tick`  out  TICK_W  delay to `Wait.tick`; held stable from START through WAIT.
- `tmr_out`  in  1  expiry from `Wait.out`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  timeout pulse; tied 0 when the timeout feature is not compiled in.

## Operation

- FSM states: IDLE, START, WAIT, DONE. All outputs are decoded from registered state plus the latched index and tick (Moore).
- **IDLE:**
  - If any `req` bit is set, select the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Latch `idx` and `tick = req_tick[idx]`.
  - Next state is START if `tick != 0`, or DONE if `tick == 0` (the timer is skipped).
- **START:**
  - `tmr_start = 1` and `gnt[idx] = 1`; go to WAIT.
- **WAIT:**
  - `gnt[idx] = 1`; `tmr_out` is sampled only in this state.
  - `tmr_out = 1` takes the FSM to DONE.
- **DONE:**
  - `done[idx] = 1` and `gnt[idx] = 1`.
  - `rr_ptr <= (idx+1) mod N_REQ`; go to IDLE.
- **Round-robin:** after any grant completes, the most recently served requester has the lowest priority.
- **Boundary and error cases:**
  - A requester dropping `req` after grant does not abort; its `done` still pulses.
  - A `tmr_out` pulse seen in IDLE, START or DONE is ignored.
  - `req_tick` changes after the latch do not affect the operation in progress.
  - `idx` is always less than `N_REQ`; `req` bits at or above `N_REQ` do not exist.
- **Reset (including mid-operation):**
  - State goes to IDLE; `rr_ptr`, `idx` and `tick` go to 0.
  - All outputs go to 0: `gnt`, `done`, `tmr_start`, `tmr_tick`, `busy`, `err`.
  - No `done` is issued for the aborted operation.

## Timing

- `req` sampled high at edge k (FSM in IDLE): state is START after edge k, so `tmr_start` and `gnt` are high for cycle k..k+1.
- `tmr_out` high at the edge that ends cycle m in WAIT: `done` is high for the next cycle.
- Overhead per grant is 3 cycles plus the timer latency.
- With `tick == 0`, `done` follows 1 cycle after grant and `tmr_start` never pulses.
- Back-to-back operation: IDLE lasts exactly 1 cycle between grants. The next grant's START begins 2 cycles after the `done` cycle begins.
- `busy` rises with START (or DONE when `tick == 0`) and falls when IDLE is entered.

## Configuration

- Macro: `WAIT_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches 255 with no `tmr_out`, go to DONE with `err = 1` for that same cycle, pulsed together with `done[idx]`.
  - The counter resets to 0.
- **Undefined:**
  - No counter is built; WAIT persists until `tmr_out`.
  - `err` is constant 0.

## Test plan

- Reset, then `req = 0001`, `req_tick[0] = 3`, bench `Wait` model:
  - `tmr_start` pulses once with `tmr_tick = 3`;
  - `done[0]` pulses 1 cycle after `tmr_out`;
  - `gnt = 0001` throughout;
  - `busy` drops afterwards.
- All four requesters held high, ticks 1/2/3/4: grant order is 0,1,2,3,0; each is granted exactly once per round.
- `req = 0100` with `req_tick[2] = 0`: `done[2]` 1 cycle after grant; `tmr_start` never asserted.
- Assert `rst_n = 0` during WAIT for requester 1:
  - all outputs are 0 asynchronously;
  - no `done[1]` is issued;
  - after release, a held `req[1]` is re-granted starting from `rr_ptr = 0` order.
- Stray `tmr_out` pulse while IDLE, then a request with tick 5: the stray pulse is ignored; the real `done` follows the model's expiry only.
- With `WAIT_ARB_TIMEOUT_EN` and the model never asserting `tmr_out`: `err` and `done[idx]` pulse together 255 cycles after WAIT entry. Without the macro, `busy` stays high.
